// File: rtl/wb_commit_multi.sv
// rtl/wb_commit_multi.sv - multi-lane in-order commit stage
// Retires up to LANES instructions per cycle, drives RegFile writes, flush, halt and instret.
module wb_commit_multi #(
  parameter int               LANES    = 2,
  parameter int               XLEN     = 32,
  parameter int               RA_W     = 5,
  parameter int               EX_W     = 4,
  parameter logic [XLEN-1:0]  TRAP_VEC = 32'h0000_0100,
  parameter int               CNT_W    = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES-1:0]        in_valid,
  output logic                    in_ready,
  input  logic [LANES*XLEN-1:0]   in_pc,
  input  logic [LANES*5-1:0]      in_opcode,
  input  logic [LANES-1:0]        in_nop,
  input  logic [LANES*XLEN-1:0]   in_result,
  input  logic [LANES*RA_W-1:0]   in_rd,
  input  logic [LANES-1:0]        in_exc_valid,
  input  logic [LANES*EX_W-1:0]   in_exc_code,
  input  logic [LANES-1:0]        in_halt,
  output logic [LANES-1:0]        wr_en,
  output logic [LANES*RA_W-1:0]   wr_addr,
  output logic [LANES*XLEN-1:0]   wr_data,
  output logic                    flush,
  output logic [XLEN-1:0]         flush_addr,
  output logic [XLEN-1:0]         exc_pc,
  output logic [EX_W-1:0]         exc_cause,
  output logic                    halt_out,
  output logic [CNT_W-1:0]        instret
);

  localparam logic [4:0] OP_LOAD      = 5'b00000;
  localparam logic [4:0] OP_IMM_ARITH = 5'b00100;
  localparam logic [4:0] OP_AUIPC     = 5'b00101;
  localparam logic [4:0] OP_ARITH     = 5'b01100;
  localparam logic [4:0] OP_LUI       = 5'b01101;
  localparam logic [4:0] OP_JALR      = 5'b11001;
  localparam logic [4:0] OP_JAL       = 5'b11011;

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALTED} state_t;

  state_t                  r_state, w_state_nxt;
  logic [LANES-1:0]        r_wr_en;
  logic [LANES*RA_W-1:0]   r_wr_addr;
  logic [LANES*XLEN-1:0]   r_wr_data;
  logic [XLEN-1:0]         r_exc_pc;
  logic [EX_W-1:0]         r_exc_cause;
  logic [CNT_W-1:0]        r_instret;

  logic                    w_accept;
  logic                    w_prefix_ok;
  logic                    w_stopped;
  logic                    w_stop_exc;
  logic                    w_stop_halt;
  logic [LANES-1:0]        w_retire;
  logic [LANES-1:0]        w_elig;
  logic [LANES-1:0]        w_wr_en;
  logic [XLEN-1:0]         w_exc_pc;
  logic [EX_W-1:0]         w_exc_code;
  logic [CNT_W-1:0]        w_nret;

  assign w_accept = (r_state == ST_RUN) && in_valid[0];

  // Walk lanes oldest first; the first exception or halt ends the retiring prefix.
  always_comb begin
    w_prefix_ok = 1'b1;
    w_stopped   = 1'b0;
    w_stop_exc  = 1'b0;
    w_stop_halt = 1'b0;
    w_retire    = '0;
    w_exc_pc    = '0;
    w_exc_code  = '0;
    w_nret      = '0;
    for (int k = 0; k < LANES; k++) begin
      w_prefix_ok = w_prefix_ok && in_valid[k];
      if (w_prefix_ok && !w_stopped) begin
        if (in_exc_valid[k]) begin
          w_stopped  = 1'b1;
          w_stop_exc = 1'b1;
          w_exc_pc   = in_pc[k*XLEN +: XLEN];
          w_exc_code = in_exc_code[k*EX_W +: EX_W];
        end else begin
          w_retire[k] = 1'b1;
          w_nret      = w_nret + CNT_W'(1);
          if (in_halt[k]) begin
            w_stopped   = 1'b1;
            w_stop_halt = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_elig = '0;
    for (int k = 0; k < LANES; k++) begin
      w_elig[k] = w_retire[k] && !in_nop[k] && (in_rd[k*RA_W +: RA_W] != '0) &&
                  (in_opcode[k*5 +: 5] inside {OP_IMM_ARITH, OP_ARITH, OP_LOAD, OP_JAL,
                                               OP_JALR, OP_LUI, OP_AUIPC});
    end
  end

  // A younger writer to the same rd shadows every older one in the bundle.
  always_comb begin
    w_wr_en = w_elig;
    for (int k = 0; k < LANES; k++) begin
      for (int j = k + 1; j < LANES; j++) begin
        if (w_elig[j] && (in_rd[j*RA_W +: RA_W] == in_rd[k*RA_W +: RA_W])) begin
          w_wr_en[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_accept && w_stop_exc) begin
          w_state_nxt = ST_FLUSH;
        end else if (w_accept && w_stop_halt) begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_FLUSH:  w_state_nxt = ST_RUN;
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en     <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_exc_pc    <= '0;
      r_exc_cause <= '0;
      r_instret   <= '0;
    end else begin
      r_wr_en   <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      if (w_accept) begin
        r_wr_en   <= w_wr_en;
        r_instret <= r_instret + w_nret;
        for (int k = 0; k < LANES; k++) begin
          if (w_wr_en[k]) begin
            r_wr_addr[k*RA_W +: RA_W] <= in_rd[k*RA_W +: RA_W];
            r_wr_data[k*XLEN +: XLEN] <= in_result[k*XLEN +: XLEN];
          end
        end
        if (w_stop_exc) begin
          r_exc_pc    <= w_exc_pc;
          r_exc_cause <= w_exc_code;
        end
      end
    end
  end

  assign in_ready   = (r_state == ST_RUN);
  assign flush      = (r_state == ST_FLUSH);
  assign flush_addr = flush ? TRAP_VEC : '0;
  assign halt_out   = (r_state == ST_HALTED);
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign exc_pc     = r_exc_pc;
  assign exc_cause  = r_exc_cause;
  assign instret    = r_instret;

endmodule

// File: tb/tb_wb_commit_multi.sv
// tb/tb_wb_commit_multi.sv - directed and random checks of wb_commit_multi against a bundle-level model
// A second instance with a 4-bit counter exercises instret wrap-around.
module tb_wb_commit_multi;

  localparam logic [4:0] OP_LOAD = 5'b00000, OP_IMM = 5'b00100, OP_AUIPC = 5'b00101,
                         OP_STORE = 5'b01000, OP_ARITH = 5'b01100, OP_LUI = 5'b01101,
                         OP_BRANCH = 5'b11000, OP_JALR = 5'b11001, OP_JAL = 5'b11011,
                         OP_SYSTEM = 5'b11100;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  in_valid, in_nop, in_exc_valid, in_halt;
  logic [63:0] in_pc, in_result;
  logic [9:0]  in_opcode, in_rd;
  logic [7:0]  in_exc_code;

  logic        in_ready, flush, halt_out;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [31:0] flush_addr, exc_pc;
  logic [3:0]  exc_cause;
  logic [63:0] instret;

  logic        s_in_ready, s_flush, s_halt_out;
  logic [1:0]  s_wr_en;
  logic [9:0]  s_wr_addr;
  logic [63:0] s_wr_data;
  logic [31:0] s_flush_addr, s_exc_pc;
  logic [3:0]  s_exc_cause;
  logic [3:0]  s_instret;

  wb_commit_multi dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_opcode(in_opcode), .in_nop(in_nop), .in_result(in_result), .in_rd(in_rd),
    .in_exc_valid(in_exc_valid), .in_exc_code(in_exc_code), .in_halt(in_halt),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush),
    .flush_addr(flush_addr), .exc_pc(exc_pc), .exc_cause(exc_cause),
    .halt_out(halt_out), .instret(instret)
  );

  wb_commit_multi #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc),
    .in_opcode(in_opcode), .in_nop(in_nop), .in_result(in_result), .in_rd(in_rd),
    .in_exc_valid(in_exc_valid), .in_exc_code(in_exc_code), .in_halt(in_halt),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .flush(s_flush),
    .flush_addr(s_flush_addr), .exc_pc(s_exc_pc), .exc_cause(s_exc_cause),
    .halt_out(s_halt_out), .instret(s_instret)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          m_mode;          // 0 run, 1 flush, 2 halted
  logic [63:0] m_instret;
  logic [31:0] m_exc_pc;
  logic [3:0]  m_exc_cause;
  logic [1:0]  m_wr_en;
  logic [9:0]  m_wr_addr;
  logic [63:0] m_wr_data;
  logic [4:0]  ops [10] = '{OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_ARITH,
                            OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit writes_reg(input logic [4:0] op);
    return op inside {OP_IMM, OP_ARITH, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  endfunction

  task automatic clear_lanes();
    in_valid = '0; in_nop = '0; in_exc_valid = '0; in_halt = '0;
    in_pc = '0; in_result = '0; in_opcode = '0; in_rd = '0; in_exc_code = '0;
  endtask

  task automatic set_lane(input int k, input logic [4:0] op, input logic [4:0] rd,
                          input logic [31:0] res, input bit nop, input bit exc,
                          input logic [3:0] code, input bit halt, input logic [31:0] pc);
    in_valid[k] = 1'b1;
    in_opcode[k*5 +: 5] = op;
    in_rd[k*5 +: 5] = rd;
    in_result[k*32 +: 32] = res;
    in_nop[k] = nop;
    in_exc_valid[k] = exc;
    in_exc_code[k*4 +: 4] = code;
    in_halt[k] = halt;
    in_pc[k*32 +: 32] = pc;
  endtask

  // Bundle-level model: count the leading valid lanes, retire up to the first stop, then let
  // the youngest writer of each rd win via a last-writer table.
  task automatic model_step();
    int nv, nret, last_writer[32];
    bit ex, hl;
    nv = 0; nret = 0; ex = 0; hl = 0;
    m_wr_en = '0; m_wr_addr = '0; m_wr_data = '0;
    if (m_mode != 0) begin
      if (m_mode == 1) m_mode = 0;
      return;
    end
    if (!in_valid[0]) return;
    while (nv < 2 && in_valid[nv]) nv++;
    for (int k = 0; k < nv; k++) begin
      if (in_exc_valid[k]) begin
        ex = 1;
        m_exc_pc = in_pc[k*32 +: 32];
        m_exc_cause = in_exc_code[k*4 +: 4];
        break;
      end
      nret++;
      if (in_halt[k]) begin
        hl = 1;
        break;
      end
    end
    foreach (last_writer[i]) last_writer[i] = -1;
    for (int k = 0; k < nret; k++)
      if (!in_nop[k] && writes_reg(in_opcode[k*5 +: 5]) && in_rd[k*5 +: 5] != 0)
        last_writer[in_rd[k*5 +: 5]] = k;
    for (int k = 0; k < nret; k++)
      if (!in_nop[k] && writes_reg(in_opcode[k*5 +: 5]) && in_rd[k*5 +: 5] != 0 &&
          last_writer[in_rd[k*5 +: 5]] == k) begin
        m_wr_en[k] = 1'b1;
        m_wr_addr[k*5 +: 5] = in_rd[k*5 +: 5];
        m_wr_data[k*32 +: 32] = in_result[k*32 +: 32];
      end
    m_instret = m_instret + 64'(nret);
    m_mode = ex ? 1 : (hl ? 2 : 0);
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".in_ready"}, in_ready, m_mode == 0);
    chk({tag, ".flush"}, flush, m_mode == 1);
    chk({tag, ".flush_addr"}, flush_addr, (m_mode == 1) ? 64'h100 : 64'h0);
    chk({tag, ".halt_out"}, halt_out, m_mode == 2);
    chk({tag, ".wr_en"}, wr_en, m_wr_en);
    chk({tag, ".wr_addr"}, wr_addr, m_wr_addr);
    chk({tag, ".wr_data"}, wr_data, m_wr_data);
    chk({tag, ".exc_pc"}, exc_pc, m_exc_pc);
    chk({tag, ".exc_cause"}, exc_cause, m_exc_cause);
    chk({tag, ".instret"}, instret, m_instret);
    chk({tag, ".instret4"}, s_instret, m_instret[3:0]);
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    m_mode = 0; m_instret = '0; m_exc_pc = '0; m_exc_cause = '0;
    m_wr_en = '0; m_wr_addr = '0; m_wr_data = '0;
    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_lanes();
    @(negedge clk);
    do_reset("reset");

    set_lane(0, OP_ARITH, 5'd3, 32'h11, 0, 0, 4'd0, 0, 32'h10);
    set_lane(1, OP_LUI, 5'd4, 32'h22000, 0, 0, 4'd0, 0, 32'h14);
    step("two_writes");
    chk("two_writes.wr_en_const", wr_en, 2'b11);
    chk("two_writes.data_const", wr_data, {32'h22000, 32'h11});
    chk("two_writes.instret_const", instret, 64'd2);

    clear_lanes();
    set_lane(0, OP_ARITH, 5'd5, 32'hAA, 0, 0, 4'd0, 0, 32'h18);
    set_lane(1, OP_IMM, 5'd5, 32'hBB, 0, 0, 4'd0, 0, 32'h1C);
    step("same_rd");
    chk("same_rd.wr_en_const", wr_en, 2'b10);
    chk("same_rd.data_const", wr_data[63:32], 32'hBB);

    clear_lanes();
    set_lane(0, OP_ARITH, 5'd0, 32'h1, 0, 0, 4'd0, 0, 32'h20);
    set_lane(1, OP_ARITH, 5'd0, 32'h2, 0, 0, 4'd0, 0, 32'h24);
    step("rd_zero");
    chk("rd_zero.instret_const", instret, 64'd6);

    clear_lanes();
    set_lane(0, OP_LOAD, 5'd7, 32'h77, 0, 0, 4'd0, 0, 32'h40);
    set_lane(1, OP_ARITH, 5'd8, 32'h88, 0, 1, 4'd2, 0, 32'h44);
    step("exc_lane1");
    chk("exc_lane1.flush_const", flush, 1'b1);
    chk("exc_lane1.exc_pc_const", exc_pc, 32'h44);
    chk("exc_lane1.ready_const", in_ready, 1'b0);
    step("after_flush");

    clear_lanes();
    set_lane(0, OP_ARITH, 5'd9, 32'h99, 0, 1, 4'd5, 1, 32'h50);
    set_lane(1, OP_ARITH, 5'd10, 32'hA0, 0, 0, 4'd0, 0, 32'h54);
    step("exc_lane0");
    step("exc_lane0_flush_cycle");

    clear_lanes();
    in_valid = 2'b10;
    in_opcode = {OP_ARITH, OP_ARITH};
    in_rd = {5'd6, 5'd6};
    step("valid_gap");

    clear_lanes();
    set_lane(0, OP_ARITH, 5'd1, 32'h101, 0, 0, 4'd0, 1, 32'h60);
    set_lane(1, OP_ARITH, 5'd2, 32'h202, 0, 0, 4'd0, 0, 32'h64);
    step("halt_lane0");
    chk("halt_lane0.wr_en_const", wr_en, 2'b01);
    step("halted_1");
    step("halted_2");
    chk("halted.sticky_const", halt_out, 1'b1);
    do_reset("reset_from_halt");
    chk("reset_from_halt.ready_const", in_ready, 1'b1);

    for (int i = 0; i < 7; i++) begin
      clear_lanes();
      set_lane(0, OP_ARITH, 5'd11, 32'(i), 0, 0, 4'd0, 0, 32'h70);
      set_lane(1, OP_ARITH, 5'd12, 32'(i), 0, 0, 4'd0, 0, 32'h74);
      step("fill");
    end
    clear_lanes();
    set_lane(0, OP_ARITH, 5'd11, 32'h5, 0, 0, 4'd0, 0, 32'h78);
    step("fill_15");
    clear_lanes();
    set_lane(0, OP_ARITH, 5'd13, 32'h6, 0, 0, 4'd0, 0, 32'h7C);
    set_lane(1, OP_ARITH, 5'd14, 32'h7, 0, 0, 4'd0, 0, 32'h80);
    step("wrap");
    chk("wrap.instret4_const", s_instret, 4'd1);

    for (int it = 0; it < 400; it++) begin
      clear_lanes();
      for (int k = 0; k < 2; k++)
        set_lane(k, ops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                 4'($urandom_range(0, 15)), $urandom_range(0, 11) == 0, $urandom);
      in_valid = 2'($urandom_range(0, 3));
      if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 80) == 0)
        do_reset("rand_reset");
      else
        step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
